// File: rtl/tff_pkg.sv
//------------------------------------------------------------------------------
// Module   : tff_pkg
// Brief    : Shared FSM state type and default width for the T-FF counter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package tff_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/tff_cell.sv
//------------------------------------------------------------------------------
// Module   : tff_cell
// Brief    : Single T flip-flop stage with synchronous active-high reset.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/tff_count_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tff_count_ctrl
// Brief    : Start/stop/load controller driving a bank of T flip-flops as a
//            modulo up/down counter. TFF_CTRL_ONESHOT_EN makes a wrap end RUN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tff_count_ctrl
  import tff_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_val,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] up_chain;
  logic [WIDTH-1:0] dn_chain;
  logic             terminal;

  // Stage i toggles when all lower bits are 1 (up) or all 0 (down).
  assign up_chain[0] = 1'b1;
  assign dn_chain[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign up_chain[gi] = up_chain[gi-1] & count[gi-1];
      assign dn_chain[gi] = dn_chain[gi-1] & ~count[gi-1];
    end
  endgenerate

  assign terminal = up_dn ? (count == mod_val) : (count == '0);

`ifdef TFF_CTRL_ONESHOT_EN
  logic done_q;
  logic done_d;
`endif

  always_comb begin
    state_d = state_q;
    t_vec   = '0;
`ifdef TFF_CTRL_ONESHOT_EN
    done_d  = 1'b0;
`endif
    if (load) begin
      // Load wins over counting but still lets start/stop move the FSM.
      t_vec = count ^ load_val;
      if (state_q == IDLE && start) begin
        state_d = RUN;
      end else if (state_q == RUN && stop) begin
        state_d = IDLE;
      end
    end else if (state_q == RUN) begin
      if (stop) begin
        state_d = IDLE;
      end else if (terminal) begin
        t_vec = up_dn ? count : mod_val;
`ifdef TFF_CTRL_ONESHOT_EN
        state_d = IDLE;
        done_d  = 1'b1;
`endif
      end else begin
        t_vec = up_dn ? up_chain : dn_chain;
      end
    end else if (start) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef TFF_CTRL_ONESHOT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;
`else
  assign done = 1'b0;
`endif

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bank
      tff_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .t     (t_vec[gi]),
        .q     (count[gi])
      );
    end
  endgenerate

  assign busy = (state_q == RUN);
  assign tc   = (state_q == RUN) && terminal;

endmodule

`default_nettype wire
